// File: rtl/vpi_access_sched.sv
// Round-robin scheduler that funnels NREQ VPI-style get/put requesters onto one
// backend command port, one transaction at a time, with a WAIT timeout.
module vpi_access_sched #(
    parameter int NREQ = 4,
    parameter int HW   = 8,
    parameter int DW   = 32,
    parameter int TMO  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*HW-1:0] req_handle,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               be_valid,
    input  logic               be_ready,
    output logic               be_write,
    output logic [HW-1:0]      be_handle,
    output logic [DW-1:0]      be_wdata,
    input  logic               be_done,
    input  logic [DW-1:0]      be_rdata,
    output logic               busy,
    output logic [7:0]         err_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic            wr_q, wr_d;
    logic [HW-1:0]   handle_q, handle_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [7:0]      err_count_q, err_count_d;

    logic            grant_any;
    logic [IW-1:0]   grant_idx;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        // NOTE: every variable assigned in a comb block gets a default first so no latch is inferred.
        idx       = 0;
        cand      = '0;
        grant_any = 1'b0;
        grant_idx = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IW'(idx);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Next-state and datapath capture.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        wr_d        = wr_q;
        handle_d    = handle_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        err_count_d = err_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    state_d  = S_ISSUE;
                    last_d   = grant_idx;
                    gnt_d    = grant_idx;
                    wr_d     = req_write[grant_idx];
                    handle_d = req_handle[int'(grant_idx)*HW +: HW];
                    wdata_d  = req_wdata[int'(grant_idx)*DW +: DW];
                end
            end
            S_ISSUE: begin
                if (be_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (be_done) begin
                    rdata_d = wr_q ? '0 : be_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == 8'(TMO - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and response state: synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments only.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= IW'(NREQ - 1);
            rdata_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // NOTE: captured request fields and the wait counter are only read in states entered after they are loaded, so they carry no reset.
    always_ff @(posedge clk) begin
        gnt_q    <= gnt_d;
        wr_q     <= wr_d;
        handle_q <= handle_d;
        wdata_q  <= wdata_d;
        cnt_q    <= cnt_d;
    end

    // Outputs decoded from state.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        be_valid  = 1'b0;
        busy      = (state_q != S_IDLE);
        if (state_q == S_IDLE && grant_any && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state_q == S_ISSUE) begin
            be_valid = 1'b1;
        end
        if (state_q == S_RESP) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign be_write  = wr_q;
    assign be_handle = handle_q;
    assign be_wdata  = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign err_count = err_count_q;

endmodule

// File: doc/vpi_access_sched.md
VPI_ACCESS_SCHED -- requirements
Module: vpi_access_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter HW, default 8, meaning the handle index width.
REQ-003 The block SHALL have parameter DW, default 32, meaning the data width.
REQ-004 The block SHALL have parameter TMO, default 15, meaning the maximum cycles in WAIT before timeout (1..255).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, meaning reset; it is synchronous and active-low.
REQ-007 The block SHALL have port req_valid, input, NREQ, meaning per-requester access request.
REQ-008 The block SHALL have port req_write, input, NREQ, meaning per-requester access type (1 = put_value, 0 = get_value).
REQ-009 The block SHALL have port req_handle, input, NREQ*HW, meaning the packed per-requester handle index, with requester i at bits [i*HW +: HW].
REQ-010 The block SHALL have port req_wdata, input, NREQ*DW, meaning the packed per-requester write data.
REQ-011 The block SHALL have port req_ready, output, NREQ, meaning one-hot request accept.
REQ-012 The block SHALL have port rsp_valid, output, NREQ, meaning a one-hot, single-cycle response strobe.
REQ-013 The block SHALL have port rsp_rdata, output, DW, meaning read data, valid with rsp_valid.
REQ-014 The block SHALL have port rsp_err, output, 1, meaning timeout flag, valid with rsp_valid.
REQ-015 The block SHALL have port be_valid, output, 1, meaning backend command valid.
REQ-016 The block SHALL have port be_ready, input, 1, meaning backend command accept.
REQ-017 The block SHALL have ports be_write (output, 1), be_handle (output, HW) and be_wdata (output, DW), meaning backend command fields.
REQ-018 The block SHALL have port be_done, input, 1, meaning backend completion pulse.
REQ-019 The block SHALL have port be_rdata, input, DW, meaning backend read data, valid with be_done.
REQ-020 The block SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-021 The block SHALL have port err_count, output, 8, meaning a saturating timeout counter.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; busy = (state != IDLE).
REQ-023 In IDLE, grant SHALL be the first asserted req_valid bit searched round-robin from (last+1) mod NREQ; req_ready = grant one-hot, combinational, and zero outside IDLE.
REQ-024 On req_valid[g] & req_ready[g], the block SHALL capture g, req_write[g], handle and wdata; set last <= g; and go to ISSUE.
REQ-025 In ISSUE, be_valid SHALL be 1 with the captured fields held stable; on be_ready the FSM goes to WAIT with wait counter = 0.
REQ-026 In WAIT, on be_done the block SHALL capture be_rdata (forced to 0 for writes), set err = 0, and go to RESP.
REQ-027 In WAIT, without be_done, the counter SHALL increment; when the counter equals TMO-1 and be_done is low, set err = 1, rdata = 0, increment err_count (saturating at 255), and go to RESP.
REQ-028 be_done SHALL be ignored in IDLE, ISSUE and RESP (late completions are dropped).
REQ-029 In RESP, rsp_valid[g] SHALL be 1 for exactly one cycle, with rsp_rdata and rsp_err registered; the next state is IDLE.
REQ-030 rsp_rdata and rsp_err SHALL hold their values until the next RESP.
REQ-031 Minimum latency, measured from accept to rsp_valid, SHALL be 3 cycles (be_ready and be_done each asserted on their first opportunity).
REQ-032 At most one transaction SHALL be outstanding; new requests wait in IDLE.
REQ-033 be_write, be_handle and be_wdata SHALL be don't-care when be_valid = 0.

Reset
REQ-034 When rst_n = 0 at a clock edge, the block SHALL force state = IDLE, last = NREQ-1, req_ready/rsp_valid/be_valid = 0, rsp_rdata = 0, rsp_err = 0, err_count = 0 and busy = 0.
REQ-035 Reset mid-transaction (in ISSUE, WAIT or RESP) SHALL abandon the transaction with no rsp_valid issued, and subsequent be_done SHALL be ignored.

Verification
REQ-036 The bench SHALL drive a single read: req_valid = 0001, handle 0x12; be_ready held 1; be_done 2 cycles after the be handshake with be_rdata = 0xDEADBEEF. Required response: rsp_valid = 0001 once, rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-037 The bench SHALL check round-robin: req_valid = 1111 held after reset, so grant order is 0,1,2,3,0; then with req_valid = 1010, grant order is 1,3,1.
REQ-038 The bench SHALL check timeout: TMO = 15, with be_done never asserted. Required response: rsp_valid after 15 WAIT cycles, rsp_err = 1, rsp_rdata = 0, err_count = 1; a late be_done in IDLE produces no response.
REQ-039 The bench SHALL check backpressure and writes: be_ready low for 5 cycles on a write of 0xA5A5A5A5 to handle 0x07. Required response: be fields stable all 5 cycles, req_ready = 0 throughout, rsp_rdata = 0.
REQ-040 The bench SHALL check reset in WAIT: rst_n = 0 for 1 cycle. Required response: busy = 0 and no rsp_valid; the next request from requester 0 is granted first.
REQ-041 The bench SHALL check saturation: 260 timeouts, after which err_count = 255.
